weight_row_loader: RTL

Write-side counterpart of the weight row mux. Accepts weight rows one at a time over a valid/ready handshake and packs them into a registered ROW_COUNT-slot bus whose layout is exactly what the row mux consumes: slot k at bits [ROW_SIZE*(k+1)-1 : ROW_SIZE*k], and select value k picks slot k. Sits between the weight memory/stream interface and the weight row mux in the neuron datapath.

---
 rtl/weight_row_loader_if.sv | 25 ++
 rtl/weight_row_loader.sv | 80 ++++++++
 2 files changed

// File: rtl/weight_row_loader_if.sv
// Row-load bus between the weight stream source and weight_row_loader.
// The master drives Start and the row handshake; the loader (slave) returns ready, pointer, bank and Done.
interface weight_row_loader_if #(
  parameter int ROW_SIZE  = 532,
  parameter int ROW_COUNT = 28,
  parameter int ADDR_BIT  = 5
);
  logic                          Start;
  logic                          InValid;
  logic [ROW_SIZE-1:0]           InRow;
  logic                          InReady;
  logic [ADDR_BIT-1:0]           WrPtr;
  logic [ROW_SIZE*ROW_COUNT-1:0] Out;
  logic                          Done;

  modport master (
    output Start, InValid, InRow,
    input  InReady, WrPtr, Out, Done
  );

  modport slave (
    input  Start, InValid, InRow,
    output InReady, WrPtr, Out, Done
  );
endinterface

// File: rtl/weight_row_loader.sv
// Packs streamed weight rows into the registered slot bank read by the row mux; a row lands on Out at its accept edge.
// InReady is high only while loading (pure state decode); Start restarts from slot 0 without clearing the bank.
module weight_row_loader #(
  parameter int ROW_SIZE  = 532,
  parameter int ROW_COUNT = 28,
  parameter int ADDR_BIT  = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  weight_row_loader_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } state_t;

  localparam logic [ADDR_BIT-1:0] LAST_SLOT = ADDR_BIT'(ROW_COUNT - 1);

  state_t                        state;
  logic [ADDR_BIT-1:0]           wr_ptr;
  logic [ROW_SIZE*ROW_COUNT-1:0] bank;
  logic                          done;
  logic                          xfer;

  // A Start coinciding with a valid row wins: the row is dropped and the pointer rewinds.
  assign xfer = (state == LOAD) && bus.InValid && !bus.Start;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      wr_ptr <= '0;
      bank   <= '0;
      done   <= 1'b0;
    end else begin
      if (xfer) begin
        for (int k = 0; k < ROW_COUNT; k++) begin
          if (wr_ptr == ADDR_BIT'(k)) begin
            bank[k*ROW_SIZE +: ROW_SIZE] <= bus.InRow;
          end
        end
      end

      case (state)
        IDLE, FULL: begin
          if (bus.Start) begin
            state  <= LOAD;
            wr_ptr <= '0;
            done   <= 1'b0;
          end
        end
        LOAD: begin
          if (bus.Start) begin
            wr_ptr <= '0;
          end else if (bus.InValid) begin
            if (wr_ptr == LAST_SLOT) begin
              state  <= FULL;
              done   <= 1'b1;
              wr_ptr <= '0;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          wr_ptr <= '0;
          done   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.InReady = (state == LOAD);
  assign bus.WrPtr   = wr_ptr;
  assign bus.Out     = bank;
  assign bus.Done    = done;

endmodule
